// File: rtl/sm_regdump_pkg.sv
// sm_regdump_pkg: FSM encoding and ASCII constants shared by the register dumper.
package sm_regdump_pkg;
  typedef enum logic [2:0] {IDLE, SETADDR, CAPTURE, LOAD, SEND, NEXT, DONE} state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int CHARS_PER_REG = 9;
endpackage

// File: rtl/sm_regdump_if.sv
// sm_regdump_if: debug-port, control and serial signals of the register dumper.
interface sm_regdump_if;
  logic start;
  logic [4:0] reg_addr;
  logic [31:0] reg_data;
  logic tx;
  logic busy;
  logic done;
  modport master (output start, reg_data, input reg_addr, tx, busy, done);
  modport slave (input start, reg_data, output reg_addr, tx, busy, done);
endinterface

// File: rtl/sm_regdump_uart_tx.sv
// sm_uart_tx: 8N1 UART transmitter, one byte per accepted tx_valid.
module sm_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);
  localparam int CW = $clog2(BAUD_DIV);
  logic [CW-1:0] baud;
  logic [9:0] sh;
  logic [3:0] bits;
  logic active;
  // sh holds {stop, data, start}; ones shift in so the line idles high
  always_ff @(posedge clk)
    if (!rst_n) begin
      active <= 1'b0;
      sh <= '1;
      bits <= '0;
      baud <= '0;
    end else if (!active) begin
      if (tx_valid) begin
        active <= 1'b1;
        sh <= {1'b1, tx_data, 1'b0};
        bits <= '0;
        baud <= '0;
      end
    end else if (baud == CW'(BAUD_DIV - 1)) begin
      baud <= '0;
      sh <= {1'b1, sh[9:1]};
      bits <= bits + 4'd1;
      if (bits == 4'd9) active <= 1'b0;
    end else begin
      baud <= baud + CW'(1);
    end
  assign tx_ready = !active;
  assign tx = active ? sh[0] : 1'b1;
endmodule

// File: rtl/sm_regdump.sv
// sm_regdump: walks the CPU debug port and streams each register as 8 hex digits + LF over UART.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int NREGS = 32
) (
  input logic clk,
  input logic rst_n,
  sm_regdump_if.slave bus
);
  state_t state, state_nx;
  logic [4:0] idx;
  logic [31:0] word;
  logic [3:0] charcnt;
  logic tx_valid, tx_ready, tx;
  logic [7:0] tx_data;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_0 + 8'(n) : ASCII_A + 8'(n) - 8'd10;
  endfunction
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? SETADDR : IDLE;
      SETADDR: state_nx = CAPTURE;
      CAPTURE: state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = !tx_ready ? SEND : (charcnt == 4'(CHARS_PER_REG - 1)) ? NEXT : LOAD;
      NEXT:    state_nx = (idx == 5'(NREGS - 1)) ? DONE : SETADDR;
      default: state_nx = IDLE;
    endcase
  end
  // the word shifts left one nibble per sent character, so [31:28] is always the next digit
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx <= '0;
      word <= '0;
      charcnt <= '0;
    end else begin
      if (state == IDLE && bus.start) idx <= '0;
      if (state == NEXT && state_nx == SETADDR) idx <= idx + 5'd1;
      if (state == CAPTURE) begin
        word <= bus.reg_data;
        charcnt <= '0;
      end
      if (state == SEND && tx_ready) begin
        word <= {word[27:0], 4'h0};
        charcnt <= charcnt + 4'd1;
      end
    end
  always_comb begin
    tx_valid = state == LOAD;
    tx_data = (charcnt == 4'(CHARS_PER_REG - 1)) ? ASCII_LF : hex_ascii(word[31:28]);
    bus.busy = state != IDLE && state != DONE;
    bus.done = state == DONE;
    bus.reg_addr = idx;
    bus.tx = tx;
  end
  sm_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: directed checks of sm_regdump with a one-register and a 32-register instance.
module tb_sm_regdump;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  sm_regdump_if b1();
  sm_regdump_if b32();
  sm_regdump #(.BAUD_DIV(BD), .NREGS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  sm_regdump #(.BAUD_DIV(BD), .NREGS(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  always #5 clk = ~clk;
  assign b32.reg_data = {27'd0, b32.reg_addr} ^ 32'hA5A5_A5A5;
  logic [7:0] q1[$];
  logic [7:0] q32[$];
  logic [4:0] aq[$];
  logic [39:0] s1, s32;
  logic [8:0] f1, f32;
  int c1 = 0, c32 = 0, bad1 = 0, bad32 = 0, d1 = 0, d32 = 0;
  logic pb = 1'b0;
  logic [4:0] pa = 5'd0;
  // 40 negedge samples per frame; every bit must hold for all 4 of its samples
  function automatic logic [8:0] decode(input logic [39:0] s);
    logic bad;
    logic [7:0] d;
    bad = s[0] | ~s[36];
    for (int k = 0; k < 10; k++) bad |= (s[4*k +: 4] != {4{s[4*k]}});
    for (int j = 0; j < 8; j++) d[j] = s[4*j + 4];
    return {bad, d};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) c1 = 0;
    else if (c1 > 0 || !b1.tx) begin
      s1[c1] = b1.tx;
      c1++;
      if (c1 == 40) begin
        f1 = decode(s1);
        bad1 += int'(f1[8]);
        q1.push_back(f1[7:0]);
        c1 = 0;
      end
    end
    if (b1.done) begin
      d1++;
      if (b1.busy) bad1++;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) c32 = 0;
    else if (c32 > 0 || !b32.tx) begin
      s32[c32] = b32.tx;
      c32++;
      if (c32 == 40) begin
        f32 = decode(s32);
        bad32 += int'(f32[8]);
        q32.push_back(f32[7:0]);
        c32 = 0;
      end
    end
    if (b32.done) begin
      d32++;
      if (b32.busy) bad32++;
    end
    if (b32.busy && (!pb || b32.reg_addr != pa)) aq.push_back(b32.reg_addr);
    pb = b32.busy;
    pa = b32.reg_addr;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_q1(input string tag, input int base, input logic [71:0] e);
    chk({tag, "_count"}, q1.size() - base, 9);
    for (int i = 0; i < 9; i++) chk({tag, "_byte"}, q1[base + i], e[71 - 8*i -: 8]);
  endtask
  task automatic wait1(input int nq, input int nd);
    for (int i = 0; i < 2000 && (q1.size() < nq || d1 < nd); i++) @(posedge clk);
  endtask
  task automatic wait32(input int nq, input int nd);
    for (int i = 0; i < 15000 && (q32.size() < nq || d32 < nd); i++) @(posedge clk);
  endtask
  task automatic pulse1();
    @(posedge clk);
    #1 b1.start = 1'b1;
    @(posedge clk);
    #1 b1.start = 1'b0;
  endtask
  task automatic pulse32();
    @(posedge clk);
    #1 b32.start = 1'b1;
    @(posedge clk);
    #1 b32.start = 1'b0;
  endtask
  initial begin
    int qb, db, bb, ab, k;
    logic [31:0] w;
    logic [7:0] e;
    string hx;
    hx = "0123456789ABCDEF";
    rst_n = 1'b0;
    b1.start = 1'b0;
    b32.start = 1'b0;
    b1.reg_data = 32'h0000_0010;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx1", b1.tx, 1);
    chk("rst_busy1", b1.busy, 0);
    chk("rst_done1", b1.done, 0);
    chk("rst_addr1", b1.reg_addr, 0);
    chk("rst_tx32", b32.tx, 1);
    chk("rst_busy32", b32.busy, 0);
    rst_n = 1'b1;
    // single register 0x00000010
    qb = q1.size(); db = d1; bb = bad1;
    pulse1();
    chk("t1_busy_rise", b1.busy, 1);
    wait1(qb + 9, db + 1);
    repeat (5) @(posedge clk);
    chk_q1("t1", qb, 72'h30_30_30_30_30_30_31_30_0A);
    chk("t1_done", d1 - db, 1);
    chk("t1_framing", bad1 - bb, 0);
    chk("t1_idle", b1.busy, 0);
    // hex letters
    b1.reg_data = 32'hDEAD_BEEF;
    qb = q1.size(); db = d1; bb = bad1;
    pulse1();
    wait1(qb + 9, db + 1);
    repeat (5) @(posedge clk);
    chk_q1("t2", qb, 72'h44_45_41_44_42_45_45_46_0A);
    chk("t2_done", d1 - db, 1);
    chk("t2_framing", bad1 - bb, 0);
    // data changes the cycle after CAPTURE: pre-change value must be sent
    b1.reg_data = 32'h1234_5678;
    qb = q1.size(); db = d1;
    pulse1();
    @(posedge clk);
    @(posedge clk);
    #1 b1.reg_data = 32'hFFFF_FFFF;
    wait1(qb + 9, db + 1);
    repeat (5) @(posedge clk);
    chk_q1("t6", qb, 72'h31_32_33_34_35_36_37_38_0A);
    // start while busy
    b1.reg_data = 32'h0000_0010;
    qb = q1.size(); db = d1;
    pulse1();
    wait1(qb + 3, 0);
    pulse1();
    wait1(qb + 9, db + 1);
    repeat (200) @(posedge clk);
    chk_q1("t4", qb, 72'h30_30_30_30_30_30_31_30_0A);
    chk("t4_done", d1 - db, 1);
    // reset during a data bit of byte 5 of register 1
    qb = q32.size(); db = d32;
    pulse32();
    wait32(qb + 14, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("t5_pre_addr", b32.reg_addr, 1);
    chk("t5_pre_busy", b32.busy, 1);
    chk("t5_pre_tx", b32.tx, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_tx", b32.tx, 1);
    chk("t5_busy", b32.busy, 0);
    chk("t5_addr", b32.reg_addr, 0);
    chk("t5_done_none", d32 - db, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // full sweep after the aborted dump
    qb = q32.size(); db = d32; bb = bad32; ab = aq.size();
    pulse32();
    wait32(qb + 288, db + 1);
    repeat (5) @(posedge clk);
    chk("t3_count", q32.size() - qb, 288);
    chk("t3_done", d32 - db, 1);
    chk("t3_framing", bad32 - bb, 0);
    chk("t3_addr_count", aq.size() - ab, 32);
    for (int r = 0; r < 32; r++) chk("t3_addr_seq", aq[ab + r], r);
    for (int i = 0; i < 288; i++) begin
      w = {27'd0, 5'(i / 9)} ^ 32'hA5A5_A5A5;
      k = i % 9;
      e = (k == 8) ? 8'h0A : hx[int'((w >> (28 - 4*k)) & 32'hF)];
      chk("t3_byte", q32[qb + i], e);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
